// File: rtl/lmac_tx_fifo_stats.sv
// Transmit FIFO for the LMAC: buffers packet words, paces packets with a
// rate-dependent inter-packet gap, and keeps packet/byte statistics.
module lmac_tx_fifo_stats #(
   parameter int DW      = 64,
   parameter int DEPTH   = 32,
   parameter int CNT_W   = 32,
   parameter int IFG_CYC = 3,
   localparam int BW     = DW / 8,
   localparam int AW     = $clog2(DEPTH),
   localparam int BCW    = $clog2(BW) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       mode,
   input  logic             tx_we,
   input  logic [DW-1:0]    tx_data,
   input  logic             tx_last,
   input  logic [BCW-1:0]   tx_bytes,
   output logic             txfifo_full,
   output logic [AW:0]      txfifo_wused,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DW-1:0]    out_data,
   output logic             out_last,
   output logic [BCW-1:0]   out_bytes,
   output logic [1:0]       tx_state,
   output logic [CNT_W-1:0] tx_pkt_sent,
   output logic [CNT_W-1:0] tx_byte_sent,
   output logic             wr_overflow
);

   localparam int EW = 1 + BCW + DW;
   localparam int GW = $clog2(IFG_CYC * 10) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_t;

   logic [EW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   wused;
   logic          empty;
   logic          wr_acc;
   logic          rd;

   state_t        state;
   state_t        state_n;
   logic [GW-1:0] gap_cnt;
   logic [GW-1:0] gap_n;
   logic [GW-1:0] gap_load;
   logic [1:0]    mode_q;
   logic [1:0]    mode_n;

   logic [15:0]   pkt_bytes;
   logic [15:0]   pkt_add;
   logic [16:0]   pkt_sum;
   logic [15:0]   pkt_sat;
   logic [BCW-1:0] eff_bytes;

   assign empty        = (wused == '0);
   assign txfifo_full  = (wused == (AW+1)'(DEPTH));
   assign txfifo_wused = wused;
   assign wr_acc       = tx_we && !txfifo_full;
   assign out_valid    = (state == SEND) && !empty;
   assign rd           = out_valid && out_ready;
   assign tx_state     = state;

   assign {out_last, out_bytes, out_data} = mem[rd_ptr];

   // Storage is deliberately left out of reset; only pointers define content.
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr] <= {tx_last, tx_bytes, tx_data};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         wused       <= '0;
         wr_overflow <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
         if (rd) rd_ptr <= rd_ptr + AW'(1);
         if (wr_acc && !rd) wused <= wused + (AW+1)'(1);
         else if (!wr_acc && rd) wused <= wused - (AW+1)'(1);
         if (tx_we && txfifo_full) wr_overflow <= 1'b1;
      end
   end

   always_comb begin
      case (mode_q)
         2'd0:    gap_load = GW'(IFG_CYC - 1);
         2'd1:    gap_load = GW'(IFG_CYC * 2 - 1);
         2'd2:    gap_load = GW'(IFG_CYC * 4 - 1);
         default: gap_load = GW'(IFG_CYC * 10 - 1);
      endcase
   end

   always_comb begin
      state_n = state;
      gap_n   = gap_cnt;
      mode_n  = mode_q;
      case (state)
         IDLE: begin
            if (!empty) begin
               state_n = SEND;
               mode_n  = mode;
            end
         end
         SEND: begin
            if (rd && out_last) begin
               state_n = GAP;
               gap_n   = gap_load;
            end
         end
         GAP: begin
            if (gap_cnt == '0) state_n = IDLE;
            else gap_n = gap_cnt - GW'(1);
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         gap_cnt <= '0;
         mode_q  <= 2'd0;
      end else begin
         state   <= state_n;
         gap_cnt <= gap_n;
         mode_q  <= mode_n;
      end
   end

   // Out-of-range byte counts on a last word are treated as a full word.
   assign eff_bytes = ((out_bytes == '0) || (out_bytes > BCW'(BW))) ? BCW'(BW) : out_bytes;
   assign pkt_add   = out_last ? 16'(eff_bytes) : 16'(BW);
   assign pkt_sum   = {1'b0, pkt_bytes} + {1'b0, pkt_add};
   assign pkt_sat   = pkt_sum[16] ? 16'hFFFF : pkt_sum[15:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pkt_bytes    <= '0;
         tx_pkt_sent  <= '0;
         tx_byte_sent <= '0;
      end else if (rd) begin
         if (out_last) begin
            pkt_bytes    <= '0;
            tx_pkt_sent  <= tx_pkt_sent + CNT_W'(1);
            tx_byte_sent <= tx_byte_sent + CNT_W'(pkt_sat);
         end else begin
            pkt_bytes <= pkt_sat;
         end
      end
   end

endmodule
